serial_word_packer: RTL

SERIAL_WORD_PACKER -- requirements
Module: serial_word_packer

---
 rtl/serial_word_packer_if.sv | 26 ++
 rtl/serial_word_packer.sv | 118 +++++++++++
 2 files changed

// File: rtl/serial_word_packer_if.sv
// Byte-stream and CPU-side bus bundle for the serial word packer.
// The master side drives the requests; the slave side is the packer.
interface serial_word_packer_if;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        cpu_rd;
   logic [15:0] rx_word;
   logic        rx_word_valid;
   logic        rx_overflow;
   logic        cpu_wr;
   logic [15:0] cpu_wdata;
   logic        tx_busy;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output rx_valid, rx_byte, cpu_rd, cpu_wr, cpu_wdata, tx_ready,
      input  rx_word, rx_word_valid, rx_overflow, tx_busy, tx_byte, tx_valid
   );

   modport slave (
      input  rx_valid, rx_byte, cpu_rd, cpu_wr, cpu_wdata, tx_ready,
      output rx_word, rx_word_valid, rx_overflow, tx_busy, tx_byte, tx_valid
   );
endinterface

// File: rtl/serial_word_packer.sv
// Packs received byte pairs little-endian into a 4-deep word FIFO and
// unpacks CPU TX words into a low-then-high byte stream.
module serial_word_packer (
   input logic                  clk,
   input logic                  rst,
   serial_word_packer_if.slave  bus
);
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 16;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned PTR_W  = 2;
   localparam int unsigned CNT_W  = 3;

   typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} tx_state_t;

   logic                phase;
   logic [BYTE_W-1:0]   lo_byte;
   logic [WORD_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;
   logic                overflow;

   logic push_c;
   logic pop_c;
   logic full_c;
   logic wr_en_c;

   // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
   assign push_c  = bus.rx_valid & phase;
   assign pop_c   = bus.cpu_rd & (count != '0);
   assign full_c  = (count == CNT_W'(DEPTH));
   assign wr_en_c = push_c & (~full_c | pop_c);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase    <= 1'b0;
         lo_byte  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else begin
         if (bus.rx_valid) begin
            phase <= ~phase;
            if (!phase) lo_byte <= bus.rx_byte;
         end
         if (wr_en_c) begin
            mem[wr_ptr] <= {bus.rx_byte, lo_byte};
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en_c, pop_c})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (push_c && !wr_en_c) overflow <= 1'b1;
      end
   end

   assign bus.rx_word       = mem[rd_ptr];
   assign bus.rx_word_valid = (count != '0);
   assign bus.rx_overflow   = overflow;

   tx_state_t         state;
   tx_state_t         state_nxt;
   logic [WORD_W-1:0] tx_word;
   logic              load_c;
   logic              tx_valid_c;
   logic              tx_busy_c;
   logic [BYTE_W-1:0] tx_byte_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        tx_word <= '0;
      else if (load_c) tx_word <= bus.cpu_wdata;
   end

   // Outputs decode from state only, so reset clears them without waiting for a clock.
   always_comb begin
      state_nxt  = state;
      load_c     = 1'b0;
      tx_valid_c = 1'b0;
      tx_busy_c  = 1'b0;
      tx_byte_c  = '0;
      case (state)
         IDLE: begin
            if (bus.cpu_wr) begin
               load_c    = 1'b1;
               state_nxt = SEND_LO;
            end
         end
         SEND_LO: begin
            tx_valid_c = 1'b1;
            tx_busy_c  = 1'b1;
            tx_byte_c  = tx_word[7:0];
            if (bus.tx_ready) state_nxt = SEND_HI;
         end
         SEND_HI: begin
            tx_valid_c = 1'b1;
            tx_busy_c  = 1'b1;
            tx_byte_c  = tx_word[15:8];
            if (bus.tx_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.tx_valid = tx_valid_c;
   assign bus.tx_busy  = tx_busy_c;
   assign bus.tx_byte  = tx_byte_c;
endmodule
